fpu_issue: RTL



---
 rtl/fpu_pkg.sv | 14 +
 rtl/fpu_issue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU operand-interface issue controller.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fpu_issue_state_t;

  localparam logic [31:0] FPU_QNAN  = 32'h7FC0_0000;
  localparam int          FPU_TMO_W = 16;

endpackage

// File: rtl/fpu_issue.sv
// Initiator side of the FPU dval/rdy operand handshake, with request/response channels.
// Optional watchdog on the WAIT state is enabled by defining FPU_ISSUE_TIMEOUT_EN.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_din1,
  input  logic [31:0]      req_din2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_din1,
  output logic [31:0]      fpu_din2,
  output logic             fpu_dval,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_rdy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             stat_stray
);

  fpu_issue_state_t state_r;
  fpu_issue_state_t state_nxt_s;

  logic             req_ready_r,  req_ready_nxt_s;
  logic             fpu_dval_r,   fpu_dval_nxt_s;
  logic             rsp_valid_r,  rsp_valid_nxt_s;
  logic [31:0]      fpu_din1_r;
  logic [31:0]      fpu_din2_r;
  logic [31:0]      rsp_data_r;
  logic [TAG_W-1:0] tag_r;
  logic             stray_r;
  logic             accept_s;
  logic             done_s;
  logic             timeout_s;

  assign accept_s = (state_r == IDLE) && req_valid;
  assign done_s   = (state_r == WAIT) && fpu_rdy;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam logic [FPU_TMO_W-1:0] TMO_LAST_C = FPU_TMO_W'(TIMEOUT - 1);

  logic [FPU_TMO_W-1:0] tmo_cnt_r;
  logic                 rsp_err_r;

  // The counter reaches TIMEOUT on the edge that ends WAIT; a same-cycle rdy wins.
  assign timeout_s = (state_r == WAIT) && !fpu_rdy && (tmo_cnt_r == TMO_LAST_C);

  // Watchdog counter and error flag for the op currently outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= {FPU_TMO_W{1'b0}};
      rsp_err_r <= 1'b0;
    end else begin
      if (state_r == ISSUE) begin
        tmo_cnt_r <= {FPU_TMO_W{1'b0}};
      end else if ((state_r == WAIT) && !fpu_rdy) begin
        tmo_cnt_r <= tmo_cnt_r + FPU_TMO_W'(1);
      end
      if (done_s) begin
        rsp_err_r <= 1'b0;
      end else if (timeout_s) begin
        rsp_err_r <= 1'b1;
      end
    end
  end

  assign rsp_err = rsp_err_r;
`else
  assign timeout_s = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_nxt_s = ISSUE;
        else           state_nxt_s = IDLE;
      end
      ISSUE: state_nxt_s = WAIT;
      WAIT: begin
        if (fpu_rdy || timeout_s) state_nxt_s = RESP;
        else                      state_nxt_s = WAIT;
      end
      RESP: begin
        if (rsp_ready) state_nxt_s = IDLE;
        else           state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state being entered, so they come straight from flops.
  always_comb begin
    req_ready_nxt_s = 1'b0;
    fpu_dval_nxt_s  = 1'b0;
    rsp_valid_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE:  req_ready_nxt_s = 1'b1;
      ISSUE: fpu_dval_nxt_s  = 1'b1;
      WAIT:  fpu_dval_nxt_s  = 1'b0;
      RESP:  rsp_valid_nxt_s = 1'b1;
      default: begin
        req_ready_nxt_s = 1'b0;
        fpu_dval_nxt_s  = 1'b0;
        rsp_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Output flops for the handshake strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_r <= 1'b1;
      fpu_dval_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      req_ready_r <= req_ready_nxt_s;
      fpu_dval_r  <= fpu_dval_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
    end
  end

  // Operand/tag capture, result capture and the sticky stray-completion flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_din1_r <= 32'h0000_0000;
      fpu_din2_r <= 32'h0000_0000;
      tag_r      <= {TAG_W{1'b0}};
      rsp_data_r <= 32'h0000_0000;
      stray_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        fpu_din1_r <= req_din1;
        fpu_din2_r <= req_din2;
        tag_r      <= req_tag;
      end
      if (done_s) begin
        rsp_data_r <= fpu_result;
      end else if (timeout_s) begin
        rsp_data_r <= FPU_QNAN;
      end
      if (fpu_rdy && (state_r != WAIT)) begin
        stray_r <= 1'b1;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign fpu_dval   = fpu_dval_r;
  assign fpu_din1   = fpu_din1_r;
  assign fpu_din2   = fpu_din2_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_tag    = tag_r;
  assign stat_stray = stray_r;

endmodule
